tri_stim_gen: RTL
=================

# tri_stim_gen

Synthesizable triangle stimulus generator that drives the rasterizer front end: it produces pseudo-random triangles on the R10 input interface (`tri_R10S`, `color_R10U`, `validTri_R10H`) and honours the rasterizer's `halt_RnnnnL` backpressure. It sends a fixed number of triangles per run and exposes an accepted-triangle count. Bench performance counters check that count against their own totals. It is the transmitting end of the interface that the bench-side performance counters observe, and it supports on-FPGA and emulation runs without a testbench file reader.

## Interface
- `SIGFIG`, 24, bits in each position/colour word
- `RADIX`, 10, fraction bits in position/colour
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex (x,y,z)
- `COLORS`, 3, colour channels
- `SCREEN_LOG2`, 9, integer bits of x/y (screen is 2^SCREEN_LOG2 pixels square)
- `NUM_TRI`, 16, triangles per run; 0 = unbounded
- `SEED`, 32'hACE1_2B3D, LFSR reset value; 0 is replaced by 32'h1
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start_RnnH` in 1: one-cycle request to begin a run
- `halt_RnnnnL` in 1: downstream ready; 1 = accept, 0 = stall
- `tri_R10S` out signed [SIGFIG-1:0] [VERTS-1:0][AXIS-1:0]: triangle vertices
- `color_R10U` out unsigned [SIGFIG-1:0] [COLORS-1:0]: triangle colour
- `validTri_R10H` out 1: triangle valid
- `done_R10H` out 1: run complete
- `tri_sent_R10U` out 32: triangles accepted in current run
- `stall_cnt_R10U` out 32: only with the configuration macro, see Configuration

## Operation
- FSM states are IDLE, GEN, SEND and DONE. Reset enters IDLE.
- IDLE/DONE: on `start_RnnH`=1, clear `tri_sent_R10U`, clear `done_R10H`, go to GEN. In DONE, `start_RnnH`=0 keeps the FSM in DONE.
- `start_RnnH` is ignored in GEN and SEND.
- GEN lasts G = VERTS*AXIS + COLORS cycles (12 by default).
  - Each GEN cycle steps the LFSR once and writes one word in order v0.x, v0.y, v0.z, v1.x … v2.z, then colour[0..COLORS-1].
  - The written word uses the post-step LFSR value L.
- LFSR: 32-bit Galois, right shift. Next = `{1'b0, L[31:1]} ^ (L[0] ? 32'h80200003 : 0)`. The LFSR is never reseeded except by reset; a new run continues the sequence.
- Word mapping from L:
  - x/y: zero-extended `L[RADIX+SCREEN_LOG2-1:0]`
  - z: zero-extended `L[SIGFIG-2:0]`, so z is always non-negative
  - colour: `L[SIGFIG-1:0]`
- SEND: `validTri_R10H`=1. Acceptance = `validTri_R10H && halt_RnnnnL` at a rising edge.
  - On acceptance, `tri_sent_R10U`+1.
  - After acceptance, go to DONE if the new count equals NUM_TRI (NUM_TRI≠0); otherwise go to GEN.
- DONE: `done_R10H`=1 and `validTri_R10H`=0.
- `tri_sent_R10U` saturates at 32'hFFFF_FFFF.

## Timing
- All outputs are registered.
- Reset values:
  - `tri_R10S`, `color_R10U`: 0
  - `validTri_R10H`, `done_R10H`: 0
  - `tri_sent_R10U`, `stall_cnt_R10U`: 0
  - LFSR: SEED (or 1 if SEED is 0)
- `start_RnnH` sampled at edge T → GEN occupies cycles T+1…T+G → `validTri_R10H` rises at T+G+1.
- Minimum triangle period with no stalls is G+1 cycles (13 by default).
- `validTri_R10H` drops in the cycle after acceptance.
- While `validTri_R10H`=1 and stalled, `tri_R10S` and `color_R10U` hold stable. They may change during GEN and are only meaningful while valid.
- `done_R10H` rises the cycle after the final acceptance.
- Reset mid-run, including mid-SEND: all outputs go to reset values immediately (asynchronously). No partial triangle is resumed.

## Configuration
- `TRI_STIM_STALL_CNT_EN` defined: the `stall_cnt_R10U` port exists.
  - It increments on each cycle with `validTri_R10H`=1 and `halt_RnnnnL`=0, and saturates.
  - It is cleared by reset and by a run start.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Free-flow: NUM_TRI=4, `halt_RnnnnL`=1, start at T → valid pulses 1 cycle wide at T+13, T+26, T+39, T+52; `done_R10H`=1 from T+53; `tri_sent_R10U`=4.
- Golden data: SEED default, no stalls → every accepted triangle's 12 words match a bench LFSR model word-for-word, with x/y < 2^19 and z ≥ 0.
- Backpressure: hold `halt_RnnnnL`=0 for 5 cycles during the first SEND → valid stays high and data stays stable for 6 cycles; one acceptance; `stall_cnt_R10U`=5 with macro.
- Start handling: start pulse during GEN → ignored, count unaffected; start in DONE → `tri_sent_R10U` cleared, `done_R10H` low, next triangle continues the LFSR sequence (no repeat of run 1).
- Async reset while in SEND → `validTri_R10H` low before the next edge; all outputs 0; a later start reproduces run 1's first triangle exactly.
- NUM_TRI=0 → 200 triangles accepted, `done_R10H` never asserts, `tri_sent_R10U`=200.

Source files
------------

// File: rtl/tri_stim_gen.sv
// Pseudo-random triangle source for the rasterizer R10 input interface, with backpressure.
// Optional stall counter port enabled by defining TRI_STIM_STALL_CNT_EN.
module tri_stim_gen #(
   parameter int unsigned SIGFIG      = 24,
   parameter int unsigned RADIX       = 10,
   parameter int unsigned VERTS       = 3,
   parameter int unsigned AXIS        = 3,
   parameter int unsigned COLORS      = 3,
   parameter int unsigned SCREEN_LOG2 = 9,
   parameter int unsigned NUM_TRI     = 16,
   parameter logic [31:0] SEED        = 32'hACE1_2B3D
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           start_RnnH,
   input  logic                                           halt_RnnnnL,
   output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
   output logic        [COLORS-1:0][SIGFIG-1:0]           color_R10U,
   output logic                                           validTri_R10H,
   output logic                                           done_R10H,
   output logic        [31:0]                             tri_sent_R10U
`ifdef TRI_STIM_STALL_CNT_EN
   ,
   output logic        [31:0]                             stall_cnt_R10U
`endif
);

   localparam int unsigned NV        = VERTS * AXIS;
   localparam int unsigned G         = NV + COLORS;
   localparam int unsigned IW        = $clog2(G + 1);
   localparam int unsigned XYW       = RADIX + SCREEN_LOG2;
   localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;

   typedef enum logic [1:0] {StIdle, StGen, StSend, StDone} state_t;

   state_t            state_q;
   logic [31:0]       lfsr_q;
   logic [31:0]       lfsr_nxt;
   logic [IW-1:0]     idx_q;
   logic [31:0]       sent_inc;
   logic [SIGFIG-1:0] xy_word;
   logic [SIGFIG-1:0] z_word;
   logic [SIGFIG-1:0] col_word;

   assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
   assign xy_word  = SIGFIG'(lfsr_nxt[XYW-1:0]);
   assign z_word   = {1'b0, lfsr_nxt[SIGFIG-2:0]};
   assign col_word = lfsr_nxt[SIGFIG-1:0];
   assign sent_inc = (tri_sent_R10U == 32'hFFFF_FFFF) ? tri_sent_R10U : tri_sent_R10U + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         lfsr_q        <= LFSR_INIT;
         idx_q         <= '0;
         tri_R10S      <= '0;
         color_R10U    <= '0;
         validTri_R10H <= 1'b0;
         done_R10H     <= 1'b0;
         tri_sent_R10U <= '0;
`ifdef TRI_STIM_STALL_CNT_EN
         stall_cnt_R10U <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_RnnH) begin
                  tri_sent_R10U <= '0;
                  done_R10H     <= 1'b0;
                  idx_q         <= '0;
                  state_q       <= StGen;
`ifdef TRI_STIM_STALL_CNT_EN
                  stall_cnt_R10U <= '0;
`endif
               end
            end
            StGen: begin
               // One word per cycle: vertices in order, then colour channels.
               lfsr_q <= lfsr_nxt;
               for (int v = 0; v < VERTS; v++) begin
                  for (int a = 0; a < AXIS; a++) begin
                     if (idx_q == IW'(v * AXIS + a)) begin
                        tri_R10S[v][a] <= (a >= 2) ? z_word : xy_word;
                     end
                  end
               end
               for (int c = 0; c < COLORS; c++) begin
                  if (idx_q == IW'(NV + c)) color_R10U[c] <= col_word;
               end
               if (idx_q == IW'(G - 1)) begin
                  validTri_R10H <= 1'b1;
                  state_q       <= StSend;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StSend: begin
               if (halt_RnnnnL) begin
                  validTri_R10H <= 1'b0;
                  tri_sent_R10U <= sent_inc;
                  idx_q         <= '0;
                  if ((NUM_TRI != 0) && (sent_inc == 32'(NUM_TRI))) begin
                     done_R10H <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     state_q <= StGen;
                  end
               end
`ifdef TRI_STIM_STALL_CNT_EN
               else if (stall_cnt_R10U != 32'hFFFF_FFFF) begin
                  stall_cnt_R10U <= stall_cnt_R10U + 32'd1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
